// File: rtl/bootram_pkg.sv
// Shared definitions for the boot RAM bus controller: FSM encoding, lane count,
// RAM word-address width and aperture size.
package bootram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_ACK  = 2'd2
  } bootram_state_t;

  localparam int          BOOTRAM_LANES          = 4;
  localparam int          BOOTRAM_AW             = 11;
  localparam logic [31:0] BOOTRAM_APERTURE_BYTES = 32'h0000_2000;

endpackage

// File: rtl/bootram_bus_ctrl.sv
// PicoRV32 native-bus slave for the 8 KB boot RAM (four 2Kx8 byte lanes in the parent).
// Optional write protection of the low WP_WORDS words is enabled with BOOTRAM_WP_EN.
module bootram_bus_ctrl
  import bootram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = BOOTRAM_AW,
  parameter int          WP_WORDS  = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [BOOTRAM_LANES-1:0] mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic                     ram_ce,
  output logic                     ram_oce,
  output logic [BOOTRAM_LANES-1:0] ram_wre,
  output logic [ADDR_W-1:0]        ram_ad,
  output logic [31:0]              ram_din,
  input  logic [31:0]              ram_dout,
  output logic                     wp_err
);

`ifdef BOOTRAM_WP_EN
  localparam bit WP_ENABLE = 1'b1;
`else
  localparam bit WP_ENABLE = 1'b0;
`endif

  localparam logic [31:0]     APERTURE_MASK = ~(BOOTRAM_APERTURE_BYTES - 32'd1);
  localparam logic [ADDR_W:0] WP_LIMIT      = WP_WORDS[ADDR_W:0];

  bootram_state_t    state;
  logic              hit;
  logic              accept;
  logic              is_write;
  logic              wp_block;
  logic [ADDR_W-1:0] word_addr;

  assign word_addr = mem_addr[ADDR_W+1:2];
  assign hit       = mem_valid && ((mem_addr & APERTURE_MASK) == (BASE_ADDR & APERTURE_MASK));
  assign accept    = (state == ST_IDLE) && hit;
  assign is_write  = |mem_wstrb;
  assign wp_block  = WP_ENABLE && ({1'b0, word_addr} < WP_LIMIT);

  // RAM strobes are only ever issued in the IDLE accept cycle, so a request
  // held across ACK can never touch the array twice.
  assign ram_ce  = accept;
  assign ram_oce = 1'b1;
  assign ram_wre = (accept && !wp_block) ? mem_wstrb : '0;
  assign ram_ad  = word_addr;
  assign ram_din = mem_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mem_ready <= 1'b0;
          if (hit) begin
            if (is_write) begin
              state     <= ST_ACK;
              mem_ready <= 1'b1;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          mem_rdata <= ram_dout;
          mem_ready <= 1'b1;
          state     <= ST_ACK;
        end
        ST_ACK: begin
          mem_ready <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          mem_ready <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BOOTRAM_WP_EN
  // Sticky until reset so firmware can poll it after the boot image is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_err <= 1'b0;
    end else if (accept && is_write && wp_block) begin
      wp_err <= 1'b1;
    end
  end
`else
  assign wp_err = 1'b0;
`endif

endmodule

// File: tb/tb_bootram_bus_ctrl.sv
// Self-checking bench for bootram_bus_ctrl: directed scenarios plus random
// accesses checked against a word-array model of the boot RAM contents.
module tb_bootram_bus_ctrl;
  import bootram_pkg::*;

`ifdef BOOTRAM_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ram_ce;
  logic        ram_oce;
  logic [3:0]  ram_wre;
  logic [10:0] ram_ad;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        wp_err;

  logic [31:0] ram_mem [0:2047];
  logic        poke_en;
  logic [10:0] poke_addr;
  logic [31:0] poke_data;

  logic [31:0] exp_mem [0:2047];
  logic [31:0] exp_rdata;
  logic        exp_wp_err;

  int          checks = 0;
  int          errors = 0;
  int          ce_cnt;
  int          wre_cnt;
  logic [3:0]  wre_seen;
  logic [10:0] ad_seen;

  bootram_bus_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ram_ce    (ram_ce),
    .ram_oce   (ram_oce),
    .ram_wre   (ram_wre),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .wp_err    (wp_err)
  );

  always #5 clk = ~clk;

  // Four byte-lane RAMs in bypass mode: read data appears the cycle after CE.
  always @(posedge clk) begin
    if (poke_en) begin
      ram_mem[poke_addr] <= poke_data;
    end else if (ram_ce) begin
      ram_dout <= ram_mem[ram_ad];
      for (int i = 0; i < 4; i++)
        if (ram_wre[i]) ram_mem[ram_ad][8*i +: 8] <= ram_din[8*i +: 8];
    end
    if (ram_ce) begin
      ce_cnt++;
      ad_seen = ram_ad;
    end
    if (ram_wre != 4'b0000) begin
      wre_cnt++;
      wre_seen = ram_wre;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transaction; the expected result comes from the word-array model.
  task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int exp_lat, input bit hold);
    int          lat;
    bit          got;
    logic [10:0] word;
    logic [3:0]  exp_wre;
    word     = addr[12:2];
    ce_cnt   = 0;
    wre_cnt  = 0;
    wre_seen = 4'b0000;
    exp_wre  = 4'b0000;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    if (wstrb == 4'b0000) begin
      exp_rdata = exp_mem[word];
    end else if (WP_ON && word < 11'd256) begin
      exp_wp_err = 1'b1;
    end else begin
      exp_wre = wstrb;
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) exp_mem[word][8*i +: 8] = wdata[8*i +: 8];
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      got = mem_ready;
    end
    check_output("ready_seen", {31'd0, got}, 32'd1);
    check_output("latency", 32'(lat), 32'(exp_lat));
    check_output("rdata", mem_rdata, exp_rdata);
    check_output("ce_count", 32'(ce_cnt), 32'd1);
    check_output("ram_ad", {21'd0, ad_seen}, {21'd0, word});
    check_output("wre_count", 32'(wre_cnt), (exp_wre != 4'b0000) ? 32'd1 : 32'd0);
    check_output("wre_value", {28'd0, wre_seen}, {28'd0, exp_wre});
    check_output("wp_err", {31'd0, wp_err}, {31'd0, exp_wp_err});
    if (!hold) begin
      mem_valid = 1'b0;
      mem_wstrb = 4'b0000;
      @(negedge clk);
      check_output("ready_pulse", {31'd0, mem_ready}, 32'd0);
    end
  endtask

  initial begin
    int   miss_ready;
    bit   prev_hold;
    bit   hold;
    logic [3:0]  ws;
    logic [31:0] a;

    reset     = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    poke_en   = 1'b0;
    poke_addr = '0;
    poke_data = '0;
    ram_dout  = '0;
    exp_rdata = '0;
    exp_wp_err = 1'b0;
    ce_cnt = 0;
    wre_cnt = 0;
    wre_seen = '0;
    ad_seen = '0;

    @(negedge clk);
    check_output("reset_ready", {31'd0, mem_ready}, 32'd0);
    check_output("reset_rdata", mem_rdata, 32'd0);
    check_output("reset_wp_err", {31'd0, wp_err}, 32'd0);
    check_output("oce_const", {31'd0, ram_oce}, 32'd1);

    for (int i = 0; i < 2048; i++) begin
      exp_mem[i] = $urandom;
      if (i == 1) exp_mem[i] = 32'h1234_5678;
      if (i == 11'h202) exp_mem[i] = 32'h1122_3344;
      poke_en   = 1'b1;
      poke_addr = 11'(i);
      poke_data = exp_mem[i];
      @(negedge clk);
    end
    poke_en = 1'b0;
    reset   = 1'b0;
    @(negedge clk);

    $display("[TB] read of word 1");
    bus_access(32'h0000_0004, 32'h0, 4'b0000, 2, 1'b0);
    check_output("t1_data", mem_rdata, 32'h1234_5678);

    $display("[TB] partial-strobe write and readback");
    bus_access(32'h0000_0808, 32'hAABB_CCDD, 4'b0101, 1, 1'b0);
    bus_access(32'h0000_0808, 32'h0, 4'b0000, 2, 1'b0);
    check_output("t2_merge", mem_rdata, 32'h11BB_33DD);

    $display("[TB] request outside aperture");
    ce_cnt = 0;
    wre_cnt = 0;
    miss_ready = 0;
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_2000;
    mem_wdata = 32'hFFFF_FFFF;
    mem_wstrb = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_ready) miss_ready++;
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    check_output("miss_ce", 32'(ce_cnt), 32'd0);
    check_output("miss_wre", 32'(wre_cnt), 32'd0);
    check_output("miss_ready", 32'(miss_ready), 32'd0);
    @(negedge clk);
    bus_access(32'h0000_0000, 32'h0, 4'b0000, 2, 1'b0);

    $display("[TB] reset while in read state");
    bus_access(32'h0000_0004, 32'h0, 4'b0000, 2, 1'b0);
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0004;
    mem_wstrb = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("rst_mid_ready", {31'd0, mem_ready}, 32'd0);
    check_output("rst_mid_rdata", mem_rdata, 32'd0);
    exp_rdata  = 32'd0;
    exp_wp_err = 1'b0;
    mem_valid  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("rst_after_ready", {31'd0, mem_ready}, 32'd0);
    bus_access(32'h0000_0020, 32'h0, 4'b0000, 2, 1'b0);

    $display("[TB] protected-region and unprotected writes");
    bus_access(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1, 1'b0);
    bus_access(32'h0000_0010, 32'h0, 4'b0000, 2, 1'b0);
    bus_access(32'h0000_0400, 32'hDEAD_BEEF, 4'b1111, 1, 1'b0);
    bus_access(32'h0000_0400, 32'h0, 4'b0000, 2, 1'b0);
    check_output("t5_stored", mem_rdata, 32'hDEAD_BEEF);

    $display("[TB] back-to-back read then write");
    bus_access(32'h0000_0030, 32'h0, 4'b0000, 2, 1'b1);
    bus_access(32'h0000_0434, 32'h5A5A_A5A5, 4'b1111, 2, 1'b1);
    bus_access(32'h0000_0434, 32'h0, 4'b0000, 3, 1'b0);
    check_output("t6_readback", mem_rdata, 32'h5A5A_A5A5);

    $display("[TB] random accesses");
    prev_hold = 1'b0;
    for (int n = 0; n < 60; n++) begin
      a    = {19'd0, 11'($urandom_range(0, 2047)), 2'($urandom_range(0, 3))};
      ws   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      hold = (n != 59) && ($urandom_range(0, 3) == 0);
      bus_access(a, $urandom, ws, ((ws == 4'b0000) ? 2 : 1) + (prev_hold ? 1 : 0), hold);
      prev_hold = hold;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
